// File: rtl/pcie_rd_req_sched.sv
// Read-request scheduler: splits a DMA read job into MRRS/4KB-bounded MRd requests,
// gated on completion credit and a free tag. Optional drain watchdog: PCIE_RD_TIMEOUT_EN.
module pcie_rd_req_sched #(
    parameter int TAG_COUNT      = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_mrrs,
    input  logic        i_job_stb,
    input  logic [63:0] i_job_addr,
    input  logic [23:0] i_job_dword_count,
    output logic        o_job_busy,
    output logic        o_job_done,
    output logic [9:0]  o_req_dword_count,
    input  logic        i_credit_ready,
    output logic        o_cmt_stb,
    output logic        o_tx_valid,
    output logic [63:0] o_tx_addr,
    output logic [9:0]  o_tx_dword_count,
    output logic [7:0]  o_tx_tag,
    input  logic        i_tx_ready,
    input  logic        i_cpl_done_stb,
    input  logic [7:0]  i_cpl_done_tag,
    output logic [8:0]  o_tags_outstanding,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_CALC, S_WAIT, S_ISSUE, S_DRAIN
    } state_t;

    state_t r_state, w_state_next;

    logic [63:0]          r_addr;
    logic [23:0]          r_remain;
    logic [10:0]          r_chunk;
    logic [9:0]           r_req_dw;
    logic [63:0]          r_tx_addr;
    logic [9:0]           r_tx_dw;
    logic [7:0]           r_tx_tag;
    logic [TAG_COUNT-1:0] r_tag_busy;
    logic [8:0]           r_outstanding;
    logic                 r_done;

    logic [10:0]          w_mrrs_dw;
    logic [12:0]          w_bound_bytes;
    logic [10:0]          w_bound_dw;
    logic [10:0]          w_limit;
    logic [10:0]          w_chunk;
    logic [23:0]          w_remain_after;
    logic [TAG_COUNT-1:0] w_rel_vec;
    logic [TAG_COUNT-1:0] w_tag_next;
    logic                 w_rel_any;
    logic                 w_free_any;
    logic [7:0]           w_free_tag;
    logic                 w_alloc;
    logic                 w_accept;
    logic                 w_drain_exit;
    logic                 w_timeout;

    // Chunk = min(remaining, MRRS, dwords to next 4KB page)
    always_comb begin
        case (i_mrrs)
            3'd0:    w_mrrs_dw = 11'd32;
            3'd1:    w_mrrs_dw = 11'd64;
            3'd2:    w_mrrs_dw = 11'd128;
            3'd3:    w_mrrs_dw = 11'd256;
            3'd4:    w_mrrs_dw = 11'd512;
            default: w_mrrs_dw = 11'd1024;
        endcase
    end

    assign w_bound_bytes  = 13'h1000 - {1'b0, r_addr[11:0]};
    assign w_bound_dw     = 11'(w_bound_bytes >> 2);
    assign w_limit        = (w_mrrs_dw < w_bound_dw) ? w_mrrs_dw : w_bound_dw;
    assign w_chunk        = (r_remain < 24'(w_limit)) ? r_remain[10:0] : w_limit;
    assign w_remain_after = r_remain - 24'(r_chunk);

    // Lowest-numbered free tag wins
    always_comb begin
        w_free_any = 1'b0;
        w_free_tag = 8'd0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!r_tag_busy[i]) begin
                w_free_any = 1'b1;
                w_free_tag = 8'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TAG_COUNT; gi++) begin : g_tag
            assign w_rel_vec[gi]  = i_cpl_done_stb && (i_cpl_done_tag == 8'(gi)) && r_tag_busy[gi];
            assign w_tag_next[gi] = (w_alloc && (w_free_tag == 8'(gi))) ||
                                    (r_tag_busy[gi] && !w_rel_vec[gi]);
        end
    endgenerate

    assign w_rel_any = |w_rel_vec;

`ifdef PCIE_RD_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout;

    assign w_timeout = (r_state == S_DRAIN) && !w_rel_any && (r_to_cnt == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_DRAIN) || w_rel_any || w_timeout) begin
            r_to_cnt <= 32'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
        r_timeout <= rst ? 1'b0 : w_timeout;
    end

    assign o_timeout = r_timeout;
`else
    assign w_timeout = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign w_drain_exit = (r_state == S_DRAIN) && ((r_outstanding == 9'd0) || w_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_job_stb) w_state_next = (i_job_dword_count == 24'd0) ? S_ZERO : S_CALC;
            S_ZERO:  w_state_next = S_IDLE;
            S_CALC:  w_state_next = S_WAIT;
            S_WAIT:  if (w_alloc) w_state_next = S_ISSUE;
            S_ISSUE: if (i_tx_ready) w_state_next = (w_remain_after != 24'd0) ? S_CALC : S_DRAIN;
            S_DRAIN: if (w_drain_exit) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_alloc    = (r_state == S_WAIT) && i_credit_ready && w_free_any;
        w_accept   = (r_state == S_ISSUE) && i_tx_ready;
        o_cmt_stb  = w_alloc;
        o_tx_valid = (r_state == S_ISSUE);
        o_job_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= 64'd0;
            r_remain      <= 24'd0;
            r_chunk       <= 11'd0;
            r_req_dw      <= 10'd0;
            r_tx_addr     <= 64'd0;
            r_tx_dw       <= 10'd0;
            r_tx_tag      <= 8'd0;
            r_tag_busy    <= '0;
            r_outstanding <= 9'd0;
            r_done        <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_job_stb) begin
                r_addr   <= i_job_addr & ~64'h3;
                r_remain <= i_job_dword_count;
            end
            if (r_state == S_CALC) begin
                r_chunk  <= w_chunk;
                r_req_dw <= w_chunk[10] ? 10'h3FF : w_chunk[9:0];
            end
            // A 1024-dword chunk naturally truncates to the 0 encoding
            if (w_alloc) begin
                r_tx_addr <= r_addr;
                r_tx_dw   <= r_chunk[9:0];
                r_tx_tag  <= w_free_tag;
            end
            if (w_accept) begin
                r_addr   <= r_addr + 64'({r_chunk, 2'b00});
                r_remain <= w_remain_after;
            end
            r_tag_busy    <= w_timeout ? '0 : w_tag_next;
            r_outstanding <= w_timeout ? 9'd0
                                       : r_outstanding + 9'(w_alloc) - 9'(w_rel_any);
            r_done        <= (r_state == S_ZERO) || w_drain_exit;
        end
    end

    assign o_job_done         = r_done;
    assign o_req_dword_count  = r_req_dw;
    assign o_tx_addr          = r_tx_addr;
    assign o_tx_dword_count   = r_tx_dw;
    assign o_tx_tag           = r_tx_tag;
    assign o_tags_outstanding = r_outstanding;

endmodule
